// File: rtl/wash_pkg.sv
// wash_pkg: shared definitions for the wash sequencer.
//   wash_state_t : sequencer states; the encoding is visible on the phase output
//   DUR_W        : width of the per-phase second counter and the sec_left output
package wash_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      WASH  = 3'd2,
      RINSE = 3'd3,
      SPIN  = 3'd4
   } wash_state_t;

   localparam int unsigned DUR_W = 16;

endpackage

// File: rtl/wash_tick_gen.sv
// wash_tick_gen: seconds prescaler.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the prescaler (state change / idle)
//   hold       : freeze the prescaler and suppress sec_tick
//   freq       : clock scale, period = TICK_BASE << freq cycles
//   sec_tick   : high in the terminal-count cycle of each second
module wash_tick_gen #(
   parameter int unsigned TICK_BASE = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       hold,
   input  logic [1:0] freq,
   output logic       sec_tick
);

   // Sized for the largest period, TICK_BASE << 3.
   localparam int unsigned CW = $clog2(TICK_BASE * 8);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] term;

   always_comb begin
      term = CW'((32'(TICK_BASE) << freq) - 32'd1);
   end

   // clr is deliberately not folded in here: the parent derives clr from
   // the state transition, which itself depends on sec_tick.
   assign sec_tick = !hold && (cnt_q == term);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (!hold) begin
         cnt_q <= (cnt_q == term) ? '0 : cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: coin-operated washing-machine phase sequencer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clk_freq    : clock scale (cycles per second = TICK_BASE << clk_freq), latched on coin
//   coin_in     : start request, sampled in IDLE only
//   extra_wash  : extra wash+rinse loops, latched on coin and clamped to MAX_EXTRA
//   timer_pause : freezes phase timing while in SPIN
//   wash_done   : high in IDLE
//   done_pulse  : one-cycle pulse in the first IDLE cycle after SPIN
//   phase       : current state encoding
//   sec_left    : seconds remaining in the current phase, 0 in IDLE
module wash_sequencer
   import wash_pkg::*;
#(
   parameter int unsigned TICK_BASE = 50_000_000,
   parameter int unsigned FILL_SEC  = 120,
   parameter int unsigned WASH_SEC  = 300,
   parameter int unsigned RINSE_SEC = 120,
   parameter int unsigned SPIN_SEC  = 60,
   parameter int unsigned MAX_EXTRA = 3,
   localparam int unsigned XW = (MAX_EXTRA < 1) ? 1 : $clog2(MAX_EXTRA + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       clk_freq,
   input  logic             coin_in,
   input  logic [XW-1:0]    extra_wash,
   input  logic             timer_pause,
   output logic             wash_done,
   output logic             done_pulse,
   output logic [2:0]       phase,
   output logic [DUR_W-1:0] sec_left
);

   if (FILL_SEC == 0 || WASH_SEC == 0 || RINSE_SEC == 0 || SPIN_SEC == 0) begin : g_zero_dur
      $error("wash_sequencer: phase durations must be non-zero");
   end
   if (FILL_SEC >= 2**DUR_W || WASH_SEC >= 2**DUR_W ||
       RINSE_SEC >= 2**DUR_W || SPIN_SEC >= 2**DUR_W) begin : g_big_dur
      $error("wash_sequencer: phase duration exceeds second counter range");
   end

   wash_state_t      state_q, state_d;
   logic [1:0]       freq_q;
   logic [XW-1:0]    extra_q, extra_d, extra_clamped;
   logic [DUR_W-1:0] sec_q, dur;
   logic             sec_tick, phase_end, clr, hold, done_q;

   wash_tick_gen #(
      .TICK_BASE (TICK_BASE)
   ) u_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .hold     (hold),
      .freq     (freq_q),
      .sec_tick (sec_tick)
   );

   always_comb begin
      dur = '0;
      case (state_q)
         FILL:    dur = DUR_W'(FILL_SEC);
         WASH:    dur = DUR_W'(WASH_SEC);
         RINSE:   dur = DUR_W'(RINSE_SEC);
         SPIN:    dur = DUR_W'(SPIN_SEC);
         default: dur = '0;
      endcase
   end

   assign phase_end     = sec_tick && (sec_q == dur - DUR_W'(1));
   assign hold          = timer_pause && (state_q == SPIN);
   assign extra_clamped = (32'(extra_wash) > MAX_EXTRA) ? XW'(MAX_EXTRA) : extra_wash;

   always_comb begin
      state_d = state_q;
      extra_d = extra_q;
      case (state_q)
         IDLE:  if (coin_in)   state_d = FILL;
         FILL:  if (phase_end) state_d = WASH;
         WASH:  if (phase_end) state_d = RINSE;
         RINSE: begin
            if (phase_end) begin
               if (extra_q != '0) begin
                  extra_d = extra_q - XW'(1);
                  state_d = WASH;
               end else begin
                  state_d = SPIN;
               end
            end
         end
         SPIN:  if (phase_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Timing restarts on every transition; IDLE keeps the prescaler parked at 0.
   assign clr = (state_d != state_q) || (state_q == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         freq_q  <= '0;
         extra_q <= '0;
         sec_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == SPIN) && (state_d == IDLE);
         if (state_q == IDLE && coin_in) begin
            freq_q  <= clk_freq;
            extra_q <= extra_clamped;
         end else begin
            extra_q <= extra_d;
         end
         if (clr) begin
            sec_q <= '0;
         end else if (sec_tick) begin
            sec_q <= sec_q + DUR_W'(1);
         end
      end
   end

   assign wash_done  = (state_q == IDLE);
   assign done_pulse = done_q;
   assign phase      = state_q;
   assign sec_left   = dur - sec_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: self-checking bench for wash_sequencer.
//   dut1 : TICK_BASE=4, FILL=2, WASH=5, RINSE=2, SPIN=1, MAX_EXTRA=3
//   dut2 : same timing, MAX_EXTRA=2 (clamp behaviour)
// A cycle-level reference model tracks phase, active-cycle count and loops
// left, and predicts phase/sec_left/wash_done/done_pulse every cycle.
module tb_wash_sequencer;

   localparam int unsigned TB_TICK = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  clk_freq = '0;
   logic        coin1 = 1'b0, coin2 = 1'b0;
   logic [1:0]  extra_wash = '0;
   logic        timer_pause = 1'b0;
   logic        wd1, wd2, dp1, dp2;
   logic [2:0]  ph1, ph2;
   logic [15:0] sl1, sl2;

   int unsigned checks = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   wash_sequencer #(
      .TICK_BASE (4), .FILL_SEC (2), .WASH_SEC (5), .RINSE_SEC (2),
      .SPIN_SEC (1), .MAX_EXTRA (3)
   ) dut1 (
      .clk (clk), .rst_n (rst_n), .clk_freq (clk_freq), .coin_in (coin1),
      .extra_wash (extra_wash), .timer_pause (timer_pause),
      .wash_done (wd1), .done_pulse (dp1), .phase (ph1), .sec_left (sl1)
   );

   wash_sequencer #(
      .TICK_BASE (4), .FILL_SEC (2), .WASH_SEC (5), .RINSE_SEC (2),
      .SPIN_SEC (1), .MAX_EXTRA (2)
   ) dut2 (
      .clk (clk), .rst_n (rst_n), .clk_freq (clk_freq), .coin_in (coin2),
      .extra_wash (extra_wash), .timer_pause (timer_pause),
      .wash_done (wd2), .done_pulse (dp2), .phase (ph2), .sec_left (sl2)
   );

   // Phase durations in seconds indexed by phase number (0 = idle).
   function automatic int unsigned dur_of(input int unsigned p);
      case (p)
         1: return 2;
         2: return 5;
         3: return 2;
         4: return 1;
         default: return 0;
      endcase
   endfunction

   task automatic do_reset();
      coin1 = 1'b0; coin2 = 1'b0; timer_pause = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Starts a wash on the selected DUT at the current negedge and follows it
   // to the first IDLE cycle. pmode: 0 no pause, 1 random pause,
   // 2 seven pause cycles mid-SPIN, 3 pause held through WASH.
   task automatic run_wash(input bit sel, input logic [1:0] freq, input logic [1:0] extra,
                           input int unsigned pmode, output int unsigned busy,
                           output int unsigned wash_entries, output int unsigned spin_len);
      int unsigned per, loops, k, mph, paused, max_x, exp_sl;
      bit          done_exp, finished, ok;
      logic [2:0]  ph_s, prev_ph;
      logic [15:0] sl_s;
      logic        wd_s, dp_s;
      max_x = sel ? 2 : 3;
      if (sel) coin2 = 1'b1; else coin1 = 1'b1;
      clk_freq = freq; extra_wash = extra; timer_pause = 1'b0;
      per = TB_TICK << freq;
      loops = (extra > max_x) ? max_x : extra;
      mph = 1; k = 0; paused = 0; done_exp = 1'b0; finished = 1'b0; ok = 1'b1;
      busy = 0; wash_entries = 0; spin_len = 0; prev_ph = 3'd1;
      @(posedge clk); @(negedge clk);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         ph_s = sel ? ph2 : ph1;
         sl_s = sel ? sl2 : sl1;
         wd_s = sel ? wd2 : wd1;
         dp_s = sel ? dp2 : dp1;
         exp_sl = (mph == 0) ? 0 : dur_of(mph) - k / per;
         checks++;
         if ({ph_s, sl_s, wd_s, dp_s} !== {3'(mph), 16'(exp_sl), (mph == 0), done_exp}) begin
            $display("FAIL run_cycle%0d dut%0d: phase=%0d sec_left=%0d wash_done=%0d done_pulse=%0d, expected phase=%0d sec_left=%0d wash_done=%0d done_pulse=%0d",
                     cyc, sel + 1, ph_s, sl_s, wd_s, dp_s, mph, exp_sl, (mph == 0), done_exp);
            failures++;
            ok = 1'b0;
            break;
         end
         if (ph_s == 3'd2 && prev_ph != 3'd2) wash_entries++;
         prev_ph = ph_s;
         if (mph == 0) begin
            finished = 1'b1;
            break;
         end
         busy++;
         if (mph == 4) spin_len++;
         // Busy-state noise: coin and the latched-at-coin inputs must be ignored.
         if (sel) coin2 = 1'($urandom_range(0, 1)); else coin1 = 1'($urandom_range(0, 1));
         clk_freq   = 2'($urandom_range(0, 3));
         extra_wash = 2'($urandom_range(0, 3));
         case (pmode)
            1: timer_pause = ($urandom_range(0, 3) == 0);
            2: timer_pause = (mph == 4 && k >= 2 && paused < 7);
            3: timer_pause = (mph == 2);
            default: timer_pause = 1'b0;
         endcase
         if (timer_pause && mph == 4) paused++;
         done_exp = 1'b0;
         if (!(timer_pause && mph == 4)) k++;
         if (k == dur_of(mph) * per) begin
            k = 0;
            case (mph)
               1: mph = 2;
               2: mph = 3;
               3: if (loops > 0) begin loops--; mph = 2; end else mph = 4;
               default: begin mph = 0; done_exp = 1'b1; end
            endcase
         end
         @(posedge clk); @(negedge clk);
      end
      coin1 = 1'b0; coin2 = 1'b0; timer_pause = 1'b0;
      if (ok) begin
         checks++;
         if (!finished) begin
            $display("FAIL run_timeout dut%0d: finished=0, expected finished=1", sel + 1);
            failures++;
            ok = 1'b0;
         end
      end
      if (!ok) do_reset();
   endtask

   task automatic test_reset();
      int unsigned busy, we, sl;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ph1, sl1, wd1, dp1, ph2, sl2, wd2, dp2} !== {3'd0, 16'd0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0}) begin
         $display("FAIL reset_state: dut1 ph=%0d sl=%0d wd=%0d dp=%0d dut2 ph=%0d sl=%0d wd=%0d dp=%0d, expected ph=0 sl=0 wd=1 dp=0",
                  ph1, sl1, wd1, dp1, ph2, sl2, wd2, dp2);
         failures++;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // Coin presented together with reset release: accepted on the next edge.
      run_wash(1'b0, 2'd0, 2'd0, 0, busy, we, sl);
      checks++;
      if (busy !== 40) begin
         $display("FAIL basic_busy_cycles: got %0d, expected 40", busy);
         failures++;
      end
      checks++;
      if (we !== 1) begin
         $display("FAIL basic_wash_entries: got %0d, expected 1", we);
         failures++;
      end
      @(negedge clk);
      checks++;
      if ({ph1, wd1, dp1} !== {3'd0, 1'b1, 1'b0}) begin
         $display("FAIL idle_after_pulse: ph=%0d wd=%0d dp=%0d, expected ph=0 wd=1 dp=0", ph1, wd1, dp1);
         failures++;
      end
   endtask

   task automatic test_extra_loops();
      int unsigned busy, we, sl;
      @(negedge clk);
      run_wash(1'b0, 2'd0, 2'd2, 0, busy, we, sl);
      checks++;
      if (busy !== 96) begin
         $display("FAIL extra2_busy_cycles: got %0d, expected 96", busy);
         failures++;
      end
      checks++;
      if (we !== 3) begin
         $display("FAIL extra2_wash_entries: got %0d, expected 3", we);
         failures++;
      end
   endtask

   task automatic test_freq_latch();
      int unsigned busy, we, sl;
      @(negedge clk);
      run_wash(1'b0, 2'd2, 2'd0, 0, busy, we, sl);
      checks++;
      if (busy !== 160) begin
         $display("FAIL freq2_busy_cycles: got %0d, expected 160", busy);
         failures++;
      end
   endtask

   task automatic test_pause();
      int unsigned busy, we, sl;
      @(negedge clk);
      run_wash(1'b0, 2'd0, 2'd0, 2, busy, we, sl);
      checks++;
      if (sl !== 11) begin
         $display("FAIL spin_pause_len: got %0d, expected 11", sl);
         failures++;
      end
      checks++;
      if (busy !== 47) begin
         $display("FAIL spin_pause_busy: got %0d, expected 47", busy);
         failures++;
      end
      @(negedge clk);
      run_wash(1'b0, 2'd0, 2'd0, 3, busy, we, sl);
      checks++;
      if (busy !== 40) begin
         $display("FAIL wash_pause_busy: got %0d, expected 40", busy);
         failures++;
      end
   endtask

   task automatic test_reset_mid_wash();
      @(negedge clk);
      coin1 = 1'b1; clk_freq = 2'd0; extra_wash = 2'd1;
      @(negedge clk);
      coin1 = 1'b1;  // coin while busy must be ignored
      repeat (11) @(negedge clk);
      checks++;
      if (ph1 !== 3'd2) begin
         $display("FAIL pre_reset_in_wash: phase=%0d, expected 2", ph1);
         failures++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ph1, sl1, wd1, dp1} !== {3'd0, 16'd0, 1'b1, 1'b0}) begin
         $display("FAIL async_reset_mid_wash: ph=%0d sl=%0d wd=%0d dp=%0d, expected ph=0 sl=0 wd=1 dp=0",
                  ph1, sl1, wd1, dp1);
         failures++;
      end
      coin1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({ph1, wd1, dp1} !== {3'd0, 1'b1, 1'b0}) begin
            $display("FAIL post_reset_idle cyc%0d: ph=%0d wd=%0d dp=%0d, expected ph=0 wd=1 dp=0",
                     i, ph1, wd1, dp1);
            failures++;
         end
      end
   endtask

   task automatic test_clamp();
      int unsigned busy, we, sl;
      @(negedge clk);
      run_wash(1'b1, 2'd0, 2'd3, 0, busy, we, sl);
      checks++;
      if (we !== 3) begin
         $display("FAIL clamp_wash_entries: got %0d, expected 3", we);
         failures++;
      end
      checks++;
      if (busy !== 96) begin
         $display("FAIL clamp_busy_cycles: got %0d, expected 96", busy);
         failures++;
      end
   endtask

   task automatic test_back_to_back();
      int unsigned busy, we, sl;
      @(negedge clk);
      for (int r = 0; r < 8; r++) begin
         run_wash(r[0], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1, busy, we, sl);
      end
   endtask

   initial begin
      test_reset();
      test_extra_loops();
      test_freq_latch();
      test_pause();
      test_reset_mid_wash();
      test_clamp();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
